// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA arithmetic stages.
// Holds the multiplier FSM state type and the default operand width.
package rsa_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rsa_mm_step.sv
// One interleaved modular-multiplication iteration (purely combinational).
// Ports: p (WIDTH+2 accumulator), a, m (WIDTH), b_bit -> p_next (WIDTH+2).
module rsa_mm_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  logic             b_bit,
    output logic [WIDTH+1:0] p_next
);

    logic [WIDTH+1:0] dbl;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] sub1;
    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] m_ext;

    assign a_ext = {2'b00, a};
    assign m_ext = {2'b00, m};

    always_comb begin
        // With p < m and a < m, 2p + a < 3m, so two subtractions suffice
        dbl    = {p[WIDTH:0], 1'b0};
        sum    = b_bit ? (dbl + a_ext) : dbl;
        sub1   = (sum >= m_ext) ? (sum - m_ext) : sum;
        p_next = (sub1 >= m_ext) ? (sub1 - m_ext) : sub1;
    end

endmodule

// File: rtl/rsa_mod_mult.sv
// Sequential interleaved modular multiplier: result = (a * b) mod m.
// Ports: clk, rst_n, start, a, b, m in; busy, done, result out.
module rsa_mod_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH+1:0] p_q;
    logic [WIDTH+1:0] p_next;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             last;

    assign last = (cnt_q == '0);

    rsa_mm_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p      (p_q),
        .a      (a_q),
        .m      (m_q),
        .b_bit  (b_q[cnt_q]),
        .p_next (p_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        m_q   <= m;
                        p_q   <= '0;
                        cnt_q <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    p_q   <= p_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (last) begin
                        // A zero modulus has no meaningful residue
                        result_q <= (m_q == '0) ? '0 : p_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: doc/rsa_mod_mult.md
# rsa_mod_mult

Sequential interleaved modular multiplier computing (a × b) mod m, one multiplier bit per clock. It is the arithmetic stage directly beneath the RSA top level. The top feeds it operands from its pins and register path. The square-and-multiply exponentiation sequencer consumes its result through a start/done handshake.

## Interface

Parameters:
- WIDTH, default 8: operand, modulus and result width in bits; must be ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only while idle.
- a  input  WIDTH  multiplicand; precondition a < m.
- b  input  WIDTH  multiplier; any value allowed.
- m  input  WIDTH  modulus.
- busy  output  1  high whenever the block is not idle.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- result  output  WIDTH  (a × b) mod m; held until the next accepted start.

## Operation

- States:
  - IDLE: waiting for start.
  - RUN: WIDTH iterations.
  - DONE: one cycle, then back to IDLE.
- IDLE with start=1:
  - latch a, b and m into internal registers;
  - clear accumulator P (WIDTH+2 bits);
  - load the bit counter with WIDTH-1;
  - go to RUN.
- RUN, one iteration per cycle, MSB of the latched b first:
  - P ← 2P;
  - if b[i], P ← P + a;
  - if P ≥ m, P ← P − m;
  - if P ≥ m again, P ← P − m;
  - decrement the counter.
- After the iteration with counter = 0: go to DONE, register P[WIDTH-1:0] into result, assert done.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE; there is no queuing.
- Input changes after acceptance do not affect the operation in flight.
- Arithmetic width:
  - P, 2P and P + a are computed at WIDTH+2 bits; no overflow is possible given a < m.
  - Comparisons are unsigned.
- Degenerate moduli:
  - m = 0 latched: result forced to 0; latency unchanged.
  - m = 1: result is 0 naturally.
- a ≥ m violates the precondition. The result is then unspecified, but the block must still complete with normal latency and return to IDLE.
- b = 0: result 0.

## Timing

- Reset values (asynchronous, immediate):
  - state = IDLE;
  - busy = 0, done = 0;
  - result = 0;
  - internal registers = 0.
- Reset asserted mid-operation aborts the operation; no done pulse is produced.
- Latency, with start sampled at edge k:
  - busy = 1 from edge k;
  - done = 1 in the cycle after edge k+WIDTH;
  - busy = 0 after edge k+WIDTH+1.
- Throughput: one multiplication per WIDTH+2 cycles.
  - start may be held high continuously; a new operation is accepted at the first edge seen in IDLE.
- busy, done and result are all registered outputs; there is no combinational path from inputs to outputs.

## Structure

- Shared package rsa_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant used by the top and the exponentiation stage.
- One sub-module is natural: rsa_mm_step, a purely combinational single-iteration datapath.
  - Inputs: P, a, m, b bit.
  - Output: the next P, including both conditional subtractions.
  - Its ports are WIDTH-parameterised.
- FSM, counter and operand registers live in rsa_mod_mult.

## Test plan

All scenarios use WIDTH = 8.

- Basic product: a=7, b=9, m=11, start pulse → done exactly 8 cycles after the start edge; result=8; busy low 9 cycles after the start edge.
- Near full range: a=200, b=255, m=251 → result=47. Then a=250, b=250, m=251 → result=1, run back-to-back with start held high; the second operation is accepted the cycle after DONE.
- Degenerate inputs:
  - m=0, a=5, b=3 → result=0;
  - m=1 → result=0;
  - b=0, a=9, m=13 → result=0;
  - in all three cases done latency is unchanged.
- Ignored start and operand isolation: pulse start and change a, b, m mid-RUN → no restart; the original result is produced, and done fires once.
- Reset mid-operation: assert rst_n=0 at iteration 4 → outputs are 0 immediately and no done follows. After release, a fresh a=3, b=4, m=5 → result=2.
- Result hold: after done, leave start low for 20 cycles → result is stable and done stays 0.
